// File: rtl/maze_pkg.sv
// maze_pkg: shared types and constants for the maze runner command path
package maze_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic {WAIT_HI, WAIT_LO} pair_state_t;
    localparam int CMD_W = 16;
    localparam int BAUD_CLKS_DEF = 2604;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 byte receiver with input synchronizer, mid-bit sampling and stop-bit check
module uart_rx
    import maze_pkg::*;
#(
    parameter int BAUD_CLKS = BAUD_CLKS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_rdy,
    output logic       frm_err,
    output logic       busy
);
    localparam int CW = $clog2(BAUD_CLKS);
    logic rx_m, rx_s, rx_q;
    rx_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bits, bits_n;
    logic [7:0] sh, sh_n;
    logic expire;

    assign expire = cnt == '0;
    assign rx_rdy = state == STOP && expire && rx_s;
    assign frm_err = state == STOP && expire && !rx_s;
    assign rx_byte = sh;
    assign busy = state != IDLE;

    // Synchronizer, edge-detect history and receiver state registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            {rx_m, rx_s, rx_q} <= 3'b111;
            state <= IDLE;
            cnt <= '0;
            bits <= '0;
            sh <= '0;
        end else begin
            {rx_m, rx_s, rx_q} <= {rx, rx_m, rx_s};
            state <= state_n;
            cnt <= cnt_n;
            bits <= bits_n;
            sh <= sh_n;
        end

    // Next-state logic: half-bit to the start centre, then full bits to each data/stop centre
    always_comb begin
        state_n = state;
        cnt_n = expire ? cnt : cnt - 1'b1;
        bits_n = bits;
        sh_n = sh;
        case (state)
            IDLE:
                if (rx_q && !rx_s) begin
                    cnt_n = CW'(BAUD_CLKS / 2 - 1);
                    state_n = START;
                end
            START:
                if (expire) begin
                    cnt_n = CW'(BAUD_CLKS - 1);
                    bits_n = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            DATA:
                if (expire) begin
                    sh_n = {rx_s, sh[7:1]};
                    cnt_n = CW'(BAUD_CLKS - 1);
                    bits_n = bits + 3'd1;
                    state_n = bits == 3'd7 ? STOP : DATA;
                end
            STOP:
                if (expire) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: rtl/uart_wrapper.sv
// uart_wrapper: pairs two UART bytes (high first) into a 16-bit command with ready/clear handshake.
// Optional low-byte timeout enabled by defining UART_WRAPPER_TIMEOUT_EN.
module uart_wrapper
    import maze_pkg::*;
#(
    parameter int BAUD_CLKS = BAUD_CLKS_DEF,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RX,
    input  logic             clr_cmd_rdy,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_rdy,
    output logic             frm_err
);
    logic [7:0] rx_byte, cmd_hi;
    logic rx_rdy, rx_busy, store_hi, store_lo, timed_out;
    pair_state_t pair, pair_n;

    uart_rx #(.BAUD_CLKS(BAUD_CLKS)) u_rx (
        .clk(clk),
        .rst_n(rst_n),
        .rx(RX),
        .rx_byte(rx_byte),
        .rx_rdy(rx_rdy),
        .frm_err(frm_err),
        .busy(rx_busy)
    );

    assign store_hi = rx_rdy && pair == WAIT_HI;
    assign store_lo = rx_rdy && pair == WAIT_LO;

    // Pair FSM next state: a good byte toggles, a timeout abandons the pending high byte
    always_comb pair_n = store_hi ? WAIT_LO : (store_lo || timed_out) ? WAIT_HI : pair;

    // Pair FSM state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pair <= WAIT_HI;
        else pair <= pair_n;

    // Command registers; a completing pair sets ready and wins over any clear
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cmd_hi <= '0;
            cmd <= '0;
            cmd_rdy <= 1'b0;
        end else begin
            cmd_hi <= store_hi ? rx_byte : timed_out ? '0 : cmd_hi;
            cmd <= store_lo ? {cmd_hi, rx_byte} : cmd;
            cmd_rdy <= store_lo || (cmd_rdy && !clr_cmd_rdy && !store_hi);
        end

`ifdef UART_WRAPPER_TIMEOUT_EN
    localparam int TO_CLKS = TIMEOUT_BITS * BAUD_CLKS;
    localparam int TW = $clog2(TO_CLKS);
    logic [TW-1:0] tcnt;

    // Count idle-receiver clocks while waiting for the low byte; frozen mid-byte
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) tcnt <= '0;
        else tcnt <= pair == WAIT_HI ? '0 : rx_busy ? tcnt : tcnt + 1'b1;

    assign timed_out = pair == WAIT_LO && !rx_busy && tcnt == TW'(TO_CLKS - 1);
`else
    assign timed_out = rx_busy && TIMEOUT_BITS < 0;
`endif
endmodule

// File: tb/tb_uart_wrapper.sv
// tb_uart_wrapper: randomized byte-stream bench checked against a byte-pairing reference model
module tb_uart_wrapper;
    localparam int B = 32;
    localparam int TO_BITS = 20;

    logic clk = 1'b0, rst_n = 1'b0, RX = 1'b1, clr_cmd_rdy = 1'b0;
    logic [15:0] cmd;
    logic cmd_rdy, frm_err;

    int n_tests = 0, n_fail = 0;
    int err_cnt = 0;
    logic [15:0] last_obs = 16'h0000;
    logic [15:0] obs_q[$], exp_q[$];

    bit m_have_hi = 0;
    logic [7:0] m_hi = 8'h00;
    logic [15:0] m_cmd = 16'h0000;
    logic m_rdy = 1'b0;
    int m_err = 0, m_gap = 0;

    uart_wrapper #(.BAUD_CLKS(B), .TIMEOUT_BITS(TO_BITS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .RX(RX),
        .clr_cmd_rdy(clr_cmd_rdy),
        .cmd(cmd),
        .cmd_rdy(cmd_rdy),
        .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frm_err) err_cnt++;
        if (cmd !== last_obs) begin
            obs_q.push_back(cmd);
            last_obs = cmd;
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        RX = v;
        repeat (B) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bit_time(1'b1);
        m_gap += n;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [15:0] w;
`ifdef UART_WRAPPER_TIMEOUT_EN
        if (m_have_hi && m_gap >= TO_BITS) m_have_hi = 0;
`endif
        if (!m_have_hi) begin
            m_have_hi = 1;
            m_hi = b;
            m_rdy = 1'b0;
        end else begin
            m_have_hi = 0;
            w = {m_hi, b};
            if (w != m_cmd) exp_q.push_back(w);
            m_cmd = w;
            m_rdy = 1'b1;
        end
        m_gap = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
        if (stop) model_byte(b);
        else m_err++;
        check("cmd", cmd, m_cmd);
        check("cmd_rdy", cmd_rdy, m_rdy);
        check("frm_err_count", err_cnt, m_err);
    endtask

    task automatic clear();
        clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b0;
        m_rdy = 1'b0;
        check("clr_rdy", cmd_rdy, 1'b0);
        check("clr_cmd", cmd, m_cmd);
    endtask

    task automatic model_reset();
        if (m_cmd != 16'h0000) exp_q.push_back(16'h0000);
        m_cmd = 16'h0000;
        m_rdy = 1'b0;
        m_have_hi = 0;
        m_gap = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd", cmd, 16'h0000);
        check("rst_rdy", cmd_rdy, 1'b0);
        check("rst_frm", frm_err, 1'b0);
        rst_n = 1'b1;
        idle(2);

        send_frame(8'h00, 1'b1);
        send_frame(8'h01, 1'b1);
        check("single_cmd", cmd, 16'h0001);
        clear();
        idle(2);

        send_frame(8'h00, 1'b1);
        send_frame(8'h02, 1'b1);
        send_frame(8'hA5, 1'b1);
        check("b2b_hi_drops_rdy", cmd_rdy, 1'b0);
        send_frame(8'hC3, 1'b1);
        check("b2b_cmd", cmd, 16'hA5C3);
        idle(2);

        RX = 1'b0;
        repeat (B / 4) @(posedge clk);
        #1;
        idle(12);
        check("glitch_frm", err_cnt, m_err);
        check("glitch_cmd", cmd, m_cmd);
        clear();
        send_frame(8'h00, 1'b1);
        send_frame(8'h03, 1'b1);
        check("glitch_next_cmd", cmd, 16'h0003);
        idle(2);

        send_frame(8'h12, 1'b0);
        idle(2);
        send_frame(8'h00, 1'b1);
        send_frame(8'h01, 1'b1);
        check("frm_then_cmd", cmd, 16'h0001);
        idle(2);

        send_frame(8'h00, 1'b1);
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_cmd", cmd, 16'h0000);
        check("midrst_rdy", cmd_rdy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        RX = 1'b1;
        rst_n = 1'b1;
        idle(12);
        send_frame(8'h00, 1'b1);
        send_frame(8'h01, 1'b1);
        check("after_rst_cmd", cmd, 16'h0001);
        idle(2);

        send_frame(8'h00, 1'b1);
        idle(25);
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
`ifdef UART_WRAPPER_TIMEOUT_EN
        check("timeout_cmd", cmd, 16'h0102);
`else
        check("timeout_cmd", cmd, 16'h0001);
`endif
        idle(2);

        for (int k = 0; k < 24; k++) begin
            send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) clear();
            idle($urandom_range(1, 3));
        end

        repeat (5) @(posedge clk);
        #1;
        check("cmd_history_len", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check("cmd_history", obs_q[i], exp_q[i]);
        check("final_frm_count", err_cnt, m_err);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
